// File: rtl/margin_table_builder_pkg.sv
// Shared encodings and slot packing for the margin table builder and its consumers.
package margin_table_builder_pkg;

  localparam int unsigned NUM_SLOTS = 6;
  localparam int unsigned NUM_PHENO = 2;

  localparam logic [1:0] GENO_AA      = 2'd0;
  localparam logic [1:0] GENO_AB      = 2'd1;
  localparam logic [1:0] GENO_BB      = 2'd2;
  localparam logic [1:0] GENO_MISSING = 2'd3;

  localparam logic PHENO_CTRL = 1'b0;
  localparam logic PHENO_CASE = 1'b1;

  typedef enum logic {StAccum, StEmit} state_e;

  // Slot k = 3*pheno + geno; the downstream divider unpacks the table the same way.
  function automatic logic [2:0] slot_idx(input logic pheno, input logic [1:0] geno);
    return (pheno == PHENO_CASE) ? (3'd3 + {1'b0, geno}) : {1'b0, geno};
  endfunction

endpackage

// File: rtl/margin_table_builder_sat_counter.sv
// Saturating up-counter; clear wins over increment so a new SNP starts from zero.
module margin_table_builder_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] nxt_o,
  output logic             sat_o
);

  localparam logic [Width-1:0] MaxVal = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count including this cycle's increment; sat_o flags an increment lost at the ceiling.
  always_comb begin
    sat_o = inc_i && (cnt_q == MaxVal);
    nxt_o = (inc_i && (cnt_q != MaxVal)) ? cnt_q + 1'b1 : cnt_q;
    cnt_d = clr_i ? '0 : nxt_o;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/margin_table_builder.sv
// Accumulates the 2x3 genotype-by-phenotype margin table for one SNP and emits it on a pulse.
module margin_table_builder
  import margin_table_builder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SAMPLE_COUNT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              geno_in,
  input  logic                    pheno_in,
  input  logic                    sample_valid_in,
  input  logic                    sample_last_in,
  output logic                    sample_ready_out,
  output logic [6*DATA_WIDTH-1:0] margin_table_out,
  output logic [2*DATA_WIDTH-1:0] n_out,
  output logic [DATA_WIDTH-1:0]   missing_out,
  output logic                    overflow_out,
  output logic                    length_err_out,
  output logic                    data_valid_out
);

  logic                    called, accept_last, miss_inc, miss_lost, lost_any, idx_sat_unused;
  logic [NUM_SLOTS-1:0]    slot_inc, slot_lost;
  logic [NUM_PHENO-1:0]    n_inc, n_lost;
  logic [DATA_WIDTH-1:0]   slot_nxt [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]   n_nxt [NUM_PHENO];
  logic [DATA_WIDTH-1:0]   miss_nxt, idx_nxt;

  logic                    ovf_q, ovf_d, ready_q, ready_d;
  logic [6*DATA_WIDTH-1:0] table_q, table_d;
  logic [2*DATA_WIDTH-1:0] n_q, n_d;
  logic [DATA_WIDTH-1:0]   miss_q, miss_d;
  logic                    ovf_out_q, ovf_out_d, len_err_q, len_err_d;
  state_e                  state_q, state_d;

  // Decode the incoming sample into per-counter increments.
  always_comb begin
    called      = geno_in inside {GENO_AA, GENO_AB, GENO_BB};
    accept_last = sample_valid_in && sample_last_in;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_inc[k] = sample_valid_in && called && (slot_idx(pheno_in, geno_in) == 3'(k));
    end
    n_inc[0] = sample_valid_in && called && (pheno_in == PHENO_CTRL);
    n_inc[1] = sample_valid_in && called && (pheno_in == PHENO_CASE);
    miss_inc = sample_valid_in && (geno_in == GENO_MISSING);
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    margin_table_builder_sat_counter #(.Width(DATA_WIDTH)) u_cnt (
      .clk_i (clk),
      .rst_ni(rst),
      .inc_i (slot_inc[k]),
      .clr_i (accept_last),
      .nxt_o (slot_nxt[k]),
      .sat_o (slot_lost[k])
    );
  end

  for (genvar i = 0; i < NUM_PHENO; i++) begin : g_n
    margin_table_builder_sat_counter #(.Width(DATA_WIDTH)) u_cnt (
      .clk_i (clk),
      .rst_ni(rst),
      .inc_i (n_inc[i]),
      .clr_i (accept_last),
      .nxt_o (n_nxt[i]),
      .sat_o (n_lost[i])
    );
  end

  margin_table_builder_sat_counter #(.Width(DATA_WIDTH)) u_miss (
    .clk_i (clk),
    .rst_ni(rst),
    .inc_i (miss_inc),
    .clr_i (accept_last),
    .nxt_o (miss_nxt),
    .sat_o (miss_lost)
  );

  // The index only feeds the length check, so its saturation never raises overflow.
  margin_table_builder_sat_counter #(.Width(DATA_WIDTH)) u_idx (
    .clk_i (clk),
    .rst_ni(rst),
    .inc_i (sample_valid_in),
    .clr_i (accept_last),
    .nxt_o (idx_nxt),
    .sat_o (idx_sat_unused)
  );

  // Sticky overflow and output-register loads on the accepted last sample.
  always_comb begin
    lost_any  = (|slot_lost) || (|n_lost) || miss_lost;
    ovf_d     = accept_last ? 1'b0 : (ovf_q || lost_any);
    ready_d   = 1'b1;
    table_d   = table_q;
    n_d       = n_q;
    miss_d    = miss_q;
    ovf_out_d = ovf_out_q;
    len_err_d = len_err_q;
    if (accept_last) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        table_d[k*DATA_WIDTH +: DATA_WIDTH] = slot_nxt[k];
      end
      for (int i = 0; i < NUM_PHENO; i++) begin
        n_d[i*DATA_WIDTH +: DATA_WIDTH] = n_nxt[i];
      end
      miss_d    = miss_nxt;
      ovf_out_d = ovf_q || lost_any;
      len_err_d = 32'(idx_nxt) != SAMPLE_COUNT;
    end
  end

  // Result, sticky-flag and ready registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
      table_q   <= '0;
      n_q       <= '0;
      miss_q    <= '0;
      ovf_out_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      table_q   <= table_d;
      n_q       <= n_d;
      miss_q    <= miss_d;
      ovf_out_q <= ovf_out_d;
      len_err_q <= len_err_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every accepted last sample leads into a pulse cycle, even from a pulse cycle.
  always_comb begin
    state_d = accept_last ? StEmit : StAccum;
  end

  // FSM outputs and held result ports.
  always_comb begin
    data_valid_out   = (state_q == StEmit);
    sample_ready_out = ready_q;
    margin_table_out = table_q;
    n_out            = n_q;
    missing_out      = miss_q;
    overflow_out     = ovf_out_q;
    length_err_out   = len_err_q;
  end

endmodule

// File: tb/tb_margin_table_builder.sv
// Bench for margin_table_builder: count-based reference model checked every cycle, plus literals.
module tb_margin_table_builder;

  localparam int unsigned DW   = 4;
  localparam int unsigned SC   = 6;
  localparam int          MAXV = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  geno_in = 2'd0;
  logic        pheno_in = 1'b0;
  logic        sample_valid_in = 1'b0;
  logic        sample_last_in = 1'b0;
  logic        sample_ready_out;
  logic [23:0] margin_table_out;
  logic [7:0]  n_out;
  logic [3:0]  missing_out;
  logic        overflow_out, length_err_out, data_valid_out;

  margin_table_builder #(.DATA_WIDTH(DW), .SAMPLE_COUNT(SC)) dut (
    .clk             (clk),
    .rst             (rst),
    .geno_in         (geno_in),
    .pheno_in        (pheno_in),
    .sample_valid_in (sample_valid_in),
    .sample_last_in  (sample_last_in),
    .sample_ready_out(sample_ready_out),
    .margin_table_out(margin_table_out),
    .n_out           (n_out),
    .missing_out     (missing_out),
    .overflow_out    (overflow_out),
    .length_err_out  (length_err_out),
    .data_valid_out  (data_valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: true (unbounded) counts per SNP, clamped only when the result is reported.
  int          m_cnt[6];
  int          m_n[2];
  int          m_miss, m_idx;
  logic [23:0] e_table = '0;
  logic [7:0]  e_n = '0;
  logic [3:0]  e_miss = '0;
  logic        e_ovf = 1'b0, e_len = 1'b0, e_valid = 1'b0, e_ready = 1'b0;

  function automatic int clamp(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_acc();
    for (int k = 0; k < 6; k++) m_cnt[k] = 0;
    m_n[0] = 0;
    m_n[1] = 0;
    m_miss = 0;
    m_idx  = 0;
  endtask

  // Advance the model by one clock edge using the stimulus the bench is driving.
  task automatic model_step();
    bit big;
    if (!rst) begin
      clear_acc();
      e_table = '0; e_n = '0; e_miss = '0;
      e_ovf = 1'b0; e_len = 1'b0; e_valid = 1'b0; e_ready = 1'b0;
      return;
    end
    e_ready = 1'b1;
    e_valid = 1'b0;
    if (sample_valid_in) begin
      m_idx++;
      if (geno_in == 2'd3) m_miss++;
      else begin
        m_cnt[3*int'(pheno_in) + int'(geno_in)]++;
        m_n[pheno_in]++;
      end
      if (sample_last_in) begin
        big = (m_miss > MAXV) || (m_n[0] > MAXV) || (m_n[1] > MAXV);
        for (int k = 0; k < 6; k++) begin
          e_table[4*k +: 4] = 4'(clamp(m_cnt[k]));
          if (m_cnt[k] > MAXV) big = 1'b1;
        end
        e_n     = {4'(clamp(m_n[1])), 4'(clamp(m_n[0]))};
        e_miss  = 4'(clamp(m_miss));
        e_ovf   = big;
        e_len   = clamp(m_idx) != SC;
        e_valid = 1'b1;
        clear_acc();
      end
    end
  endtask

  // Per-cycle comparison, 1 time unit after each rising edge.
  initial begin
    clear_acc();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("valid", 32'(data_valid_out), 32'(e_valid));
      chk("ready", 32'(sample_ready_out), 32'(e_ready));
      chk("table", 32'(margin_table_out), 32'(e_table));
      chk("n", 32'(n_out), 32'(e_n));
      chk("missing", 32'(missing_out), 32'(e_miss));
      chk("overflow", 32'(overflow_out), 32'(e_ovf));
      chk("length_err", 32'(length_err_out), 32'(e_len));
    end
  end

  task automatic send(input logic p, input logic [1:0] g, input logic last);
    @(negedge clk);
    pheno_in = p; geno_in = g; sample_valid_in = 1'b1; sample_last_in = last;
  endtask

  task automatic idle(input logic last);
    @(negedge clk);
    sample_valid_in = 1'b0; sample_last_in = last;
  endtask

  // Hand-computed expectations for the pulse following the last sample just driven.
  task automatic lit(input string name, input logic [23:0] tbl, input logic [7:0] n,
                     input logic [3:0] miss, input logic ovf, input logic len);
    @(posedge clk);
    #2;
    chk({name, "_valid"}, 32'(data_valid_out), 32'd1);
    chk({name, "_table"}, 32'(margin_table_out), 32'(tbl));
    chk({name, "_n"}, 32'(n_out), 32'(n));
    chk({name, "_missing"}, 32'(missing_out), 32'(miss));
    chk({name, "_overflow"}, 32'(overflow_out), 32'(ovf));
    chk({name, "_length_err"}, 32'(length_err_out), 32'(len));
  endtask

  task automatic snp_basic();
    send(0, 0, 0); send(0, 1, 0); send(0, 2, 0);
    send(1, 0, 0); send(1, 0, 0); send(1, 2, 1);
  endtask

  initial begin
    #1;
    chk("rst_ready", 32'(sample_ready_out), 32'd0);
    chk("rst_valid", 32'(data_valid_out), 32'd0);
    chk("rst_table", 32'(margin_table_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(0);
    idle(1);  // last without valid must be ignored
    idle(0);

    snp_basic();
    lit("basic", 24'h102111, 8'h33, 4'd0, 1'b0, 1'b0);

    // Back-to-back 4-sample SNPs.
    send(0, 0, 0); send(0, 0, 0); send(1, 1, 0); send(1, 2, 1);
    send(1, 0, 0); send(0, 2, 0); send(0, 2, 0); send(0, 1, 1);
    lit("b2b", 24'h001210, 8'h13, 4'd0, 1'b0, 1'b1);
    idle(0);

    // 10 samples, 3 missing.
    send(0, 3, 0); send(1, 1, 0); send(0, 0, 0); send(1, 3, 0); send(0, 2, 0);
    send(1, 2, 0); send(0, 1, 0); send(1, 3, 0); send(0, 0, 0); send(1, 0, 1);
    lit("missing", 24'h111112, 8'h34, 4'd3, 1'b0, 1'b1);
    idle(0);

    // Saturation, then a clean SNP must not inherit the overflow.
    for (int i = 0; i < 19; i++) send(1, 1, 0);
    send(1, 1, 1);
    lit("sat", 24'h0F0000, 8'hF0, 4'd0, 1'b1, 1'b1);
    snp_basic();
    lit("clean", 24'h102111, 8'h33, 4'd0, 1'b0, 1'b0);
    idle(0);

    // Reset mid-SNP.
    for (int i = 0; i < 5; i++) send(0, 1, 0);
    @(negedge clk);
    rst = 1'b0; sample_valid_in = 1'b0; sample_last_in = 1'b0;
    #1;
    chk("async_valid", 32'(data_valid_out), 32'd0);
    chk("async_table", 32'(margin_table_out), 32'd0);
    chk("async_ready", 32'(sample_ready_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(0);
    send(0, 0, 0); send(1, 2, 1);
    lit("after_rst", 24'h100001, 8'h11, 4'd0, 1'b0, 1'b1);

    // Single-sample SNPs on consecutive cycles.
    send(0, 1, 1);
    lit("single0", 24'h000010, 8'h01, 4'd0, 1'b0, 1'b1);
    send(1, 2, 1);
    lit("single1", 24'h100000, 8'h10, 4'd0, 1'b0, 1'b1);
    send(0, 3, 1);
    lit("single2", 24'h000000, 8'h00, 4'd1, 1'b0, 1'b1);
    idle(0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
